// File: rtl/fifo_wptr_full_if.sv
// rtl/fifo_wptr_full_if.sv - write-side pointer/status bundle of the async FIFO
//
// Purpose: groups the push request, the incoming read-domain Gray pointer and
// the write-domain status outputs of fifo_wptr_full.
// Signals:
//   winc          push request
//   rptr_gray     read-domain Gray pointer (asynchronous to the write clock)
//   waddr         RAM write address
//   wptr          registered Gray write pointer for the read domain
//   wfull         FIFO full
//   walmost_full  fill level at or above the almost-full threshold
//   wlevel        fill level seen from the write domain
//   woverflow     one-cycle pulse per push rejected while full
// Modports:
//   master  the FIFO user: drives winc/rptr_gray, observes status
//   slave   the write-pointer block itself
interface fifo_wptr_full_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 winc;
    logic [ADDR_SIZE:0]   rptr_gray;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 wfull;
    logic                 walmost_full;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 woverflow;

    modport master (
        output winc, rptr_gray,
        input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, rptr_gray,
        output waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write pointer, Gray publish and full/level status
//
// Purpose: keeps the binary write pointer, drives the RAM write address,
// publishes a registered Gray write pointer, synchronizes the read-domain Gray
// pointer through two flops and derives full, almost-full, fill level and
// overflow in the write clock domain. All outputs are registered.
// Ports:
//   wclk    write-domain clock (the only clock)
//   wrst_n  asynchronous active-low reset
//   bus     fifo_wptr_full_if.slave: winc, rptr_gray in;
//           waddr, wptr, wfull, walmost_full, wlevel, woverflow out
module fifo_wptr_full #(
    parameter int ADDR_SIZE = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wptr_full_if.slave   bus
);
    localparam int W = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE:0] AF_THRESH_W = W'(AF_THRESH);

    logic [ADDR_SIZE:0] wbin_q, wbin_d;
    logic [ADDR_SIZE:0] wptr_q, wptr_d;
    logic [ADDR_SIZE:0] rq1_q, rq2_q;
    logic [ADDR_SIZE:0] wlevel_q, wlevel_d;
    logic               wfull_q, wfull_d;
    logic               walmost_full_q, walmost_full_d;
    logic               woverflow_q, woverflow_d;

    logic               push;
    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] full_gray;

    // Gray-to-binary of the synchronized read pointer: each binary bit is the
    // XOR of all Gray bits from the MSB down to it.
    always_comb begin
        rbin            = '0;
        rbin[ADDR_SIZE] = rq2_q[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rq2_q[i];
        end
    end

    // The write pointer is exactly one lap ahead of the read pointer when its
    // Gray code equals the read Gray code with the top two bits inverted.
    assign full_gray = {~rq2_q[ADDR_SIZE:ADDR_SIZE-1], rq2_q[ADDR_SIZE-2:0]};

    always_comb begin
        push           = bus.winc & ~wfull_q;
        wbin_d         = wbin_q + {{ADDR_SIZE{1'b0}}, push};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        // Status uses the pointer after this edge's push, so a filling push
        // raises wfull with no extra latency.
        wfull_d        = (wptr_d == full_gray);
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_THRESH_W);
        woverflow_d    = bus.winc & wfull_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            rq1_q          <= '0;
            rq2_q          <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            rq1_q          <= bus.rptr_gray;
            rq2_q          <= rq1_q;
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDR_SIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.woverflow    = woverflow_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - self-checking bench for fifo_wptr_full
module tb_fifo_wptr_full;
    logic wclk;
    logic wrst_n;

    fifo_wptr_full_if #(.ADDR_SIZE(4)) bus ();

    fifo_wptr_full #(.ADDR_SIZE(4), .AF_THRESH(12)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       winc;
        logic [4:0] rg;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl [33];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic winc, input logic [4:0] rg, input logic [3:0] waddr,
                                input logic [4:0] wptr, input logic full, input logic af,
                                input logic [4:0] lvl, input logic ovf);
        vec_t v;
        v.winc = winc; v.rg = rg; v.waddr = waddr; v.wptr = wptr;
        v.full = full; v.af = af; v.lvl = lvl; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all(input string nm, input int idx, input logic [3:0] waddr,
                             input logic [4:0] wptr, input logic full, input logic af,
                             input logic [4:0] lvl, input logic ovf);
        chk({nm, "_waddr"}, idx, 32'(bus.waddr), 32'(waddr));
        chk({nm, "_wptr"},  idx, 32'(bus.wptr),  32'(wptr));
        chk({nm, "_wfull"}, idx, 32'(bus.wfull), 32'(full));
        chk({nm, "_waf"},   idx, 32'(bus.walmost_full), 32'(af));
        chk({nm, "_wlevel"}, idx, 32'(bus.wlevel), 32'(lvl));
        chk({nm, "_wovf"},  idx, 32'(bus.woverflow), 32'(ovf));
    endtask

    logic [4:0] prev_wptr;
    logic [4:0] rpos;

    initial begin
        // Fill 16 (walmost_full from 12th push, full at 16th), overflow x3,
        // read release to Gray(4) then Gray(5), refill to 15, then a push and
        // a read step on the same edge.
        tbl[0]  = mk(1, 5'h00, 4'h1, 5'h01, 0, 0, 5'd1,  0);
        tbl[1]  = mk(1, 5'h00, 4'h2, 5'h03, 0, 0, 5'd2,  0);
        tbl[2]  = mk(1, 5'h00, 4'h3, 5'h02, 0, 0, 5'd3,  0);
        tbl[3]  = mk(1, 5'h00, 4'h4, 5'h06, 0, 0, 5'd4,  0);
        tbl[4]  = mk(1, 5'h00, 4'h5, 5'h07, 0, 0, 5'd5,  0);
        tbl[5]  = mk(1, 5'h00, 4'h6, 5'h05, 0, 0, 5'd6,  0);
        tbl[6]  = mk(1, 5'h00, 4'h7, 5'h04, 0, 0, 5'd7,  0);
        tbl[7]  = mk(1, 5'h00, 4'h8, 5'h0C, 0, 0, 5'd8,  0);
        tbl[8]  = mk(1, 5'h00, 4'h9, 5'h0D, 0, 0, 5'd9,  0);
        tbl[9]  = mk(1, 5'h00, 4'hA, 5'h0F, 0, 0, 5'd10, 0);
        tbl[10] = mk(1, 5'h00, 4'hB, 5'h0E, 0, 0, 5'd11, 0);
        tbl[11] = mk(1, 5'h00, 4'hC, 5'h0A, 0, 1, 5'd12, 0);
        tbl[12] = mk(1, 5'h00, 4'hD, 5'h0B, 0, 1, 5'd13, 0);
        tbl[13] = mk(1, 5'h00, 4'hE, 5'h09, 0, 1, 5'd14, 0);
        tbl[14] = mk(1, 5'h00, 4'hF, 5'h08, 0, 1, 5'd15, 0);
        tbl[15] = mk(1, 5'h00, 4'h0, 5'h18, 1, 1, 5'd16, 0);
        tbl[16] = mk(1, 5'h00, 4'h0, 5'h18, 1, 1, 5'd16, 1);
        tbl[17] = mk(1, 5'h00, 4'h0, 5'h18, 1, 1, 5'd16, 1);
        tbl[18] = mk(1, 5'h00, 4'h0, 5'h18, 1, 1, 5'd16, 1);
        tbl[19] = mk(0, 5'h00, 4'h0, 5'h18, 1, 1, 5'd16, 0);
        tbl[20] = mk(0, 5'h06, 4'h0, 5'h18, 1, 1, 5'd16, 0);
        tbl[21] = mk(0, 5'h06, 4'h0, 5'h18, 1, 1, 5'd16, 0);
        tbl[22] = mk(0, 5'h06, 4'h0, 5'h18, 0, 1, 5'd12, 0);
        tbl[23] = mk(0, 5'h07, 4'h0, 5'h18, 0, 1, 5'd12, 0);
        tbl[24] = mk(0, 5'h07, 4'h0, 5'h18, 0, 1, 5'd12, 0);
        tbl[25] = mk(0, 5'h07, 4'h0, 5'h18, 0, 0, 5'd11, 0);
        tbl[26] = mk(1, 5'h07, 4'h1, 5'h19, 0, 1, 5'd12, 0);
        tbl[27] = mk(1, 5'h07, 4'h2, 5'h1B, 0, 1, 5'd13, 0);
        tbl[28] = mk(1, 5'h07, 4'h3, 5'h1A, 0, 1, 5'd14, 0);
        tbl[29] = mk(1, 5'h07, 4'h4, 5'h1E, 0, 1, 5'd15, 0);
        tbl[30] = mk(1, 5'h05, 4'h5, 5'h1F, 1, 1, 5'd16, 0);
        tbl[31] = mk(0, 5'h05, 4'h5, 5'h1F, 1, 1, 5'd16, 0);
        tbl[32] = mk(0, 5'h05, 4'h5, 5'h1F, 0, 1, 5'd15, 0);

        wrst_n        = 1'b0;
        bus.winc      = 1'b0;
        bus.rptr_gray = '0;
        @(negedge wclk);
        @(negedge wclk);
        check_all("reset", 0, 4'h0, 5'h00, 0, 0, 5'd0, 0);
        wrst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            bus.winc      = tbl[i].winc;
            bus.rptr_gray = tbl[i].rg;
            @(negedge wclk);
            check_all("vec", i, tbl[i].waddr, tbl[i].wptr, tbl[i].full, tbl[i].af, tbl[i].lvl, tbl[i].ovf);
        end

        // Asynchronous reset mid-cycle while pushing: outputs clear before any edge.
        bus.winc = 1'b1;
        #2 wrst_n = 1'b0;
        #1 check_all("async_rst", 0, 4'h0, 5'h00, 0, 0, 5'd0, 0);
        @(negedge wclk);
        check_all("async_rst_hold", 0, 4'h0, 5'h00, 0, 0, 5'd0, 0);
        wrst_n        = 1'b1;
        bus.rptr_gray = '0;
        @(negedge wclk);
        check_all("first_push", 0, 4'h1, 5'h01, 0, 0, 5'd1, 0);
        bus.winc = 1'b0;

        // Wrap: 80 pushes with the read pointer trailing the write pointer.
        wrst_n = 1'b0;
        @(negedge wclk);
        wrst_n    = 1'b1;
        prev_wptr = 5'h00;
        for (int n = 0; n < 80; n++) begin
            rpos          = 5'(n) - 5'd1;
            bus.rptr_gray = (n >= 1) ? gray5(rpos) : 5'h00;
            bus.winc      = 1'b1;
            @(negedge wclk);
            chk("wrap_hamming", n, 32'($countones(prev_wptr ^ bus.wptr)), 32'd1);
            chk("wrap_wfull", n, 32'(bus.wfull), 32'd0);
            chk("wrap_level_le4", n, 32'(bus.wlevel <= 5'd4), 32'd1);
            chk("wrap_waddr", n, 32'(bus.waddr), 32'((n + 1) % 16));
            prev_wptr = bus.wptr;
        end
        bus.winc      = 1'b0;
        bus.rptr_gray = gray5(5'd15);
        repeat (3) @(negedge wclk);
        check_all("wrap_settle", 0, 4'h0, 5'h18, 0, 0, 5'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
